// File: rtl/sprite_palette_pkg.sv
// Shared constants and types for the sprite palette bank.
package sprite_palette_pkg;

    // Reset contents of every palette, packed {R,G,B} with 4 bits per channel.
    localparam logic [11:0] DEFAULT_PALETTE [16] = '{
        12'h221, 12'hE00, 12'h0E0, 12'hB85,
        12'h00E, 12'h950, 12'h0EE, 12'hE0E,
        12'hEE0, 12'hFFF, 12'h888, 12'h444,
        12'hF80, 12'h08F, 12'h8F0, 12'hF08
    };

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

    // Damage-flash tint: full red, no green or blue.
    localparam rgb_t FLASH_RGB = '{red: 4'hF, green: 4'h0, blue: 4'h0};

    // Default entry i; palettes larger than 16 entries wrap around the table.
    function automatic logic [11:0] default_entry(input int i);
        return DEFAULT_PALETTE[i % 16];
    endfunction

endpackage

// File: rtl/palette_store.sv
// Double-buffered palette storage: software writes land in shadow, and a
// frame_start commit copies shadow into active. Lookups only see active.
module palette_store
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4,
    parameter int NPAL  = 4,
    parameter int PAL_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [PAL_W-1:0]     wr_pal_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [3*CH_W-1:0]    wr_data_i,
    input  logic                 frame_start_i,
    input  logic [PAL_W-1:0]     rd_pal_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [3*CH_W-1:0]    rd_data_o,
    output logic                 commit_pending_o
);

    localparam int              NE     = 2 ** IDX_W;
    localparam int              DW     = 3 * CH_W;
    localparam logic [PAL_W:0]  NPAL_L = (PAL_W + 1)'(NPAL);

    logic [DW-1:0]    shadow_q [NPAL][NE];
    logic [DW-1:0]    active_q [NPAL][NE];
    logic             pending_q;
    logic             pending_d;
    logic             wr_ok;
    logic             commit;
    logic [PAL_W-1:0] rd_sel;

    // Fit a 4-bit default channel into CH_W bits, keeping it MSB-aligned.
    function automatic logic [CH_W-1:0] scale_ch(input logic [3:0] c);
        logic [CH_W-1:0] r;
        int src;
        r = '0;
        for (int b = 0; b < CH_W; b++) begin
            src = b + 4 - CH_W;
            if (src >= 0 && src < 4) r[b] = c[src[1:0]];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] reset_entry(input int i);
        logic [11:0] d;
        d = default_entry(i);
        return {scale_ch(d[11:8]), scale_ch(d[7:4]), scale_ch(d[3:0])};
    endfunction

    // Decode write legality and whether this cycle commits; a same-cycle
    // write is folded into the commit, so it also counts as pending.
    always_comb begin
        wr_ok     = wr_en_i && ({1'b0, wr_pal_i} < NPAL_L);
        commit    = frame_start_i && (pending_q || wr_ok);
        pending_d = pending_q;
        if (commit)     pending_d = 1'b0;
        else if (wr_ok) pending_d = 1'b1;
    end

    // Shadow/active arrays: write into shadow, bulk copy on commit with the
    // concurrent write merged in (later assignment wins).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NPAL; p++) begin
                for (int i = 0; i < NE; i++) begin
                    shadow_q[p][i] <= reset_entry(i);
                    active_q[p][i] <= reset_entry(i);
                end
            end
            pending_q <= 1'b0;
        end else begin
            if (commit) begin
                for (int p = 0; p < NPAL; p++) begin
                    for (int i = 0; i < NE; i++) begin
                        active_q[p][i] <= shadow_q[p][i];
                    end
                end
            end
            if (wr_ok) begin
                shadow_q[wr_pal_i][wr_idx_i] <= wr_data_i;
                if (commit) active_q[wr_pal_i][wr_idx_i] <= wr_data_i;
            end
            pending_q <= pending_d;
        end
    end

    // Read port on the active copy; out-of-range palettes fall back to 0.
    always_comb begin
        rd_sel    = ({1'b0, rd_pal_i} < NPAL_L) ? rd_pal_i : '0;
        rd_data_o = active_q[rd_sel][rd_idx_i];
    end

    assign commit_pending_o = pending_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// Sprite palette lookup: two-stage pipeline from colour index to RGB with
// transparency flagging and damage-flash tint.
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int   IDX_W      = 4,
    parameter int   CH_W       = 4,
    parameter int   NPAL       = 4,
    parameter int   TRANSP_IDX = 0,
    localparam int  PAL_W      = (NPAL > 1) ? $clog2(NPAL) : 1
) (
    input  logic                 Clk_i,
    input  logic                 Reset_n_i,
    input  logic                 pix_valid_i,
    input  logic [PAL_W-1:0]     pix_pal_i,
    input  logic [IDX_W-1:0]     pix_idx_i,
    input  logic                 flash_en_i,
    input  logic                 wr_en_i,
    input  logic [PAL_W-1:0]     wr_pal_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [3*CH_W-1:0]    wr_data_i,
    input  logic                 frame_start_i,
    output logic                 out_valid_o,
    output logic [CH_W-1:0]      red_o,
    output logic [CH_W-1:0]      green_o,
    output logic [CH_W-1:0]      blue_o,
    output logic                 out_transp_o,
    output logic                 commit_pending_o
);

    localparam int DW = 3 * CH_W;

    logic [DW-1:0] rd_data;

    logic          s1_valid_q;
    logic          s1_flash_q;
    logic          s1_transp_q;
    logic [DW-1:0] s1_rgb_q;

    logic          out_valid_q;
    logic [DW-1:0] rgb_d;
    logic [DW-1:0] rgb_q;
    logic          transp_d;
    logic          transp_q;

    palette_store #(
        .IDX_W (IDX_W),
        .CH_W  (CH_W),
        .NPAL  (NPAL),
        .PAL_W (PAL_W)
    ) u_store (
        .clk_i            (Clk_i),
        .rst_ni           (Reset_n_i),
        .wr_en_i          (wr_en_i),
        .wr_pal_i         (wr_pal_i),
        .wr_idx_i         (wr_idx_i),
        .wr_data_i        (wr_data_i),
        .frame_start_i    (frame_start_i),
        .rd_pal_i         (pix_pal_i),
        .rd_idx_i         (pix_idx_i),
        .rd_data_o        (rd_data),
        .commit_pending_o (commit_pending_o)
    );

    // Stage 1: capture the pixel request and its active-palette colour.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            s1_valid_q  <= 1'b0;
            s1_flash_q  <= 1'b0;
            s1_transp_q <= 1'b0;
            s1_rgb_q    <= '0;
        end else begin
            s1_valid_q <= pix_valid_i;
            if (pix_valid_i) begin
                s1_flash_q  <= flash_en_i;
                s1_transp_q <= (pix_idx_i == IDX_W'(TRANSP_IDX));
                s1_rgb_q    <= rd_data;
            end
        end
    end

    // Transparent pixels keep their palette colour and ignore the flash.
    always_comb begin
        rgb_d    = s1_rgb_q;
        transp_d = s1_transp_q;
        if (!s1_transp_q && s1_flash_q) rgb_d = {{CH_W{1'b1}}, {(2*CH_W){1'b0}}};
    end

    // Stage 2: output registers; colour and transparency hold on idle cycles.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
            transp_q    <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rgb_q    <= rgb_d;
                transp_q <= transp_d;
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign red_o        = rgb_q[DW-1 -: CH_W];
    assign green_o      = rgb_q[2*CH_W-1 -: CH_W];
    assign blue_o       = rgb_q[CH_W-1:0];
    assign out_transp_o = transp_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Bench for sprite_palette_bank: directed test-plan steps then random traffic,
// checked against a palette/pipeline reference model.
module tb_sprite_palette_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [1:0]  pix_pal;
    logic [3:0]  pix_idx;
    logic        flash_en;
    logic        wr_en;
    logic [1:0]  wr_pal;
    logic [3:0]  wr_idx;
    logic [11:0] wr_data;
    logic        frame_start;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        out_transp;
    logic        commit_pending;

    sprite_palette_bank dut (
        .Clk_i            (clk),
        .Reset_n_i        (rst_n),
        .pix_valid_i      (pix_valid),
        .pix_pal_i        (pix_pal),
        .pix_idx_i        (pix_idx),
        .flash_en_i       (flash_en),
        .wr_en_i          (wr_en),
        .wr_pal_i         (wr_pal),
        .wr_idx_i         (wr_idx),
        .wr_data_i        (wr_data),
        .frame_start_i    (frame_start),
        .out_valid_o      (out_valid),
        .red_o            (red),
        .green_o          (green),
        .blue_o           (blue),
        .out_transp_o     (out_transp),
        .commit_pending_o (commit_pending)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] DEF [16] = '{
        12'h221, 12'hE00, 12'h0E0, 12'hB85, 12'h00E, 12'h950, 12'h0EE, 12'hE0E,
        12'hEE0, 12'hFFF, 12'h888, 12'h444, 12'hF80, 12'h08F, 12'h8F0, 12'hF08
    };

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        tr;
    } exp_t;

    logic [11:0] shadow_m [4][16];
    logic [11:0] active_m [4][16];
    bit          pend_m;
    logic [11:0] last_rgb;
    logic        last_tr;
    exp_t        q[$];
    int          cyc;
    int          checks;
    int          errors;

    task automatic model_reset();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++) begin
                shadow_m[p][i] = DEF[i];
                active_m[p][i] = DEF[i];
            end
        pend_m   = 0;
        last_rgb = '0;
        last_tr  = 1'b0;
        q.delete();
    endtask

    task automatic check_out();
        logic ev;
        exp_t e;
        ev = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e        = q.pop_front();
            ev       = 1'b1;
            last_rgb = e.rgb;
            last_tr  = e.tr;
        end
        checks++;
        assert (out_valid === ev) else begin
            errors++;
            $error("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev);
        end
        checks++;
        assert ({red, green, blue} === last_rgb) else begin
            errors++;
            $error("FAIL rgb cyc=%0d got=%h exp=%h", cyc, {red, green, blue}, last_rgb);
        end
        checks++;
        assert (out_transp === last_tr) else begin
            errors++;
            $error("FAIL out_transp cyc=%0d got=%b exp=%b", cyc, out_transp, last_tr);
        end
        checks++;
        assert (commit_pending === pend_m) else begin
            errors++;
            $error("FAIL commit_pending cyc=%0d got=%b exp=%b", cyc, commit_pending, pend_m);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check.
    task automatic cycle(input bit pv, input int pal, input int idx, input bit fl,
                         input bit we, input int wpal, input int widx,
                         input logic [11:0] wd, input bit fs);
        exp_t e;
        bit   wrote;
        pix_valid   = pv;
        pix_pal     = 2'(pal);
        pix_idx     = 4'(idx);
        flash_en    = fl;
        wr_en       = we;
        wr_pal      = 2'(wpal);
        wr_idx      = 4'(widx);
        wr_data     = wd;
        frame_start = fs;
        @(posedge clk);
        cyc++;
        if (pv) begin
            e.due = cyc + 1;
            e.tr  = (idx == 0);
            e.rgb = active_m[pal][idx];
            if (!e.tr && fl) e.rgb = 12'hF00;
            q.push_back(e);
        end
        wrote = we && (wpal < 4);
        if (wrote) shadow_m[wpal][widx] = wd;
        if (fs && (pend_m || wrote)) begin
            active_m = shadow_m;
            pend_m   = 0;
        end else if (wrote) begin
            pend_m = 1;
        end
        #1 check_out();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        pix_valid = 0; pix_pal = 0; pix_idx = 0; flash_en = 0;
        wr_en = 0; wr_pal = 0; wr_idx = 0; wr_data = 0; frame_start = 0;
        model_reset();
        #12;
        check_out();
        rst_n = 1'b1;

        // Plain lookup, then transparent index with flash requested
        cycle(1, 0, 1, 0, 0, 0, 0, 12'h000, 0);
        idle(2);
        cycle(1, 0, 0, 1, 0, 0, 0, 12'h000, 0);
        idle(2);

        // Shadow write is invisible until frame_start commits it
        cycle(0, 0, 0, 0, 1, 2, 5, 12'h0F0, 0);
        cycle(1, 2, 5, 0, 0, 0, 0, 12'h000, 0);
        idle(2);
        cycle(0, 0, 0, 0, 0, 0, 0, 12'h000, 1);
        cycle(1, 2, 5, 0, 0, 0, 0, 12'h000, 0);
        idle(2);

        // Write merged into a same-cycle commit; redundant frame_start
        cycle(0, 0, 0, 0, 1, 1, 3, 12'h123, 1);
        cycle(1, 1, 3, 0, 0, 0, 0, 12'h000, 1);
        idle(2);

        // Back-to-back stream with a single flashed pixel
        for (int i = 0; i < 16; i++) cycle(1, 0, i, (i == 7), 0, 0, 0, 12'h000, 0);
        idle(2);

        // Asynchronous reset in the middle of a stream
        cycle(1, 1, 3, 0, 1, 3, 9, 12'hABC, 0);
        cycle(1, 1, 3, 0, 0, 0, 0, 12'h000, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_out();
        @(posedge clk);
        #2 rst_n = 1'b1;
        cycle(1, 1, 3, 0, 0, 0, 0, 12'h000, 0);
        cycle(1, 3, 9, 0, 0, 0, 0, 12'h000, 0);
        idle(2);

        // Random traffic: pixels, writes and commits interleaved
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 15), 12'($urandom),
                  $urandom_range(0, 9) == 0);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
